acondicionador_botones: RTL and testbench

//  Conditions two raw push-buttons (up, down) into clean single-cycle command pulses
//  for the minute/hour up-down counters of the clock/timer datapath.
//  Per button: 2-FF synchronizer, debounce, and a press pulse. Optional auto-repeat.

---
 rtl/acondicionador_pkg.sv | 17 +
 rtl/canal_boton.sv | 140 ++++++++++++++
 rtl/acondicionador_botones.sv | 88 ++++++++
 tb/tb_acondicionador_botones.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acondicionador_pkg.sv
// Shared definitions for the push-button conditioner: channel state
// encoding and default timing constants (50 MHz system clock).
package acondicionador_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } estado_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 0.5 s
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 0.1 s
    localparam int unsigned DEF_CNT_W           = 25;

endpackage

// File: rtl/canal_boton.sv
// One button channel: 2-FF synchronizer, debounce FSM with a saturating
// down-counter, press pulse and (with ACONDICIONADOR_AUTO_REPEAT_EN defined)
// an auto-repeat down-counter. The pulse output is combinational and is
// registered by the parent.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | debounced level 0, synced level 0
// DEB_PRESS   | synced went 1, waiting for it to hold before accepting
// HELD        | press accepted, debounced level 1
// DEB_RELEASE | synced went 0, waiting for it to hold before releasing
module canal_boton
    import acondicionador_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
`endif
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulso,
    output logic nivel
);

    // Load value L makes the terminal count land L+1 edges after loading.
    localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    estado_t    estado_q, estado_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic       deb_done;
    logic       pulso_d;

`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic       rep_done;
    logic       rep_activo;
`endif

    assign deb_done = (deb_cnt_q == '0);

    // Synchronizer, state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            estado_q  <= IDLE;
            deb_cnt_q <= '0;
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
            rep_cnt_q <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            estado_q  <= estado_d;
            deb_cnt_q <= deb_cnt_d;
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    // Next-state, debounce counting, press and repeat pulses.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        estado_d  = estado_q;
        deb_cnt_d = deb_cnt_q;
        pulso_d   = 1'b0;
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        rep_done   = (rep_cnt_q == '0);
        rep_activo = 1'b0;
`endif

        unique case (estado_q)
            IDLE: begin
                if (sync2_q) begin
                    estado_d  = DEB_PRESS;
                    deb_cnt_d = DEB_LOAD;
                end
            end
            DEB_PRESS: begin
                if (!sync2_q) begin
                    estado_d = IDLE;
                end else if (deb_done) begin
                    estado_d = HELD;
                    pulso_d  = 1'b1;
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
                    rep_cnt_d = REP_DELAY_LOAD;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q - 1'b1;
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    estado_d  = DEB_RELEASE;
                    deb_cnt_d = DEB_LOAD;
                end
            end
            DEB_RELEASE: begin
                if (sync2_q) begin
                    estado_d = HELD;
                end else if (deb_done) begin
                    estado_d = IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q - 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase

`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
        // Repeats run while the button counts as held and stop on the very
        // edge that returns the channel to IDLE.
        rep_activo = ((estado_q == HELD) || (estado_q == DEB_RELEASE)) &&
                     (estado_d != IDLE);
        if (rep_activo) begin
            if (rep_done) begin
                pulso_d   = 1'b1;
                rep_cnt_d = REP_PERIOD_LOAD;
            end else begin
                rep_cnt_d = rep_cnt_q - 1'b1;
            end
        end
`endif
    end

    assign pulso = pulso_d;
    assign nivel = (estado_q == HELD) || (estado_q == DEB_RELEASE);

endmodule

// File: rtl/acondicionador_botones.sv
// Up/down push-button conditioner: two debounced channels, mutual-exclusion
// arbitration and registered single-cycle command pulses for the counters.
// Optional auto-repeat is enabled by defining ACONDICIONADOR_AUTO_REPEAT_EN.
module acondicionador_botones
    import acondicionador_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic boton_aumenta,
    output logic boton_disminuye
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    // Reject timing values that are zero or do not fit the counters.
    if (CNT_W < 1 || CNT_W > 32 ||
        DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        64'(DEBOUNCE_CYCLES) > CNT_MAX || 64'(REPEAT_DELAY) > CNT_MAX ||
        64'(REPEAT_PERIOD) > CNT_MAX) begin : g_param_check
        $error("acondicionador_botones: timing parameter out of range for CNT_W");
    end

    logic pulso_up, nivel_up;
    logic pulso_dn, nivel_dn;
    logic ambos;
    logic aumenta_q, aumenta_d;
    logic disminuye_q, disminuye_d;

    canal_boton #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
        .CNT_W           (CNT_W)
    ) u_canal_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_up_raw),
        .pulso   (pulso_up),
        .nivel   (nivel_up)
    );

    canal_boton #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
        .CNT_W           (CNT_W)
    ) u_canal_dn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_down_raw),
        .pulso   (pulso_dn),
        .nivel   (nivel_dn)
    );

    // A press pulse counts as that channel's debounced level going to 1 in
    // the same cycle, so simultaneous acceptances are also blocked.
    always_comb begin
        ambos       = (nivel_up | pulso_up) & (nivel_dn | pulso_dn);
        aumenta_d   = pulso_up & ~ambos;
        disminuye_d = pulso_dn & ~ambos;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            aumenta_q   <= 1'b0;
            disminuye_q <= 1'b0;
        end else begin
            aumenta_q   <= aumenta_d;
            disminuye_q <= disminuye_d;
        end
    end

    assign boton_aumenta   = aumenta_q;
    assign boton_disminuye = disminuye_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Cycle k is the k-th posedge after the
// per-test reset; outputs are sampled 1 time unit after that edge.
module tb_acondicionador_botones;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_up_raw = 1'b0;
    logic btn_down_raw = 1'b0;
    logic boton_aumenta;
    logic boton_disminuye;

    int n_tests = 0;
    int n_fail  = 0;

    acondicionador_botones #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .CNT_W           (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .btn_up_raw      (btn_up_raw),
        .btn_down_raw    (btn_down_raw),
        .boton_aumenta   (boton_aumenta),
        .boton_disminuye (boton_disminuye)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic up, input logic dn, input logic rst);
        @(negedge clk);
        btn_up_raw   = up;
        btn_down_raw = dn;
        reset        = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b1);
            n_tests++;
            if (boton_aumenta !== 1'b0 || boton_disminuye !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: aumenta=%b disminuye=%b, expected 0 0",
                         k, boton_aumenta, boton_disminuye);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [63:0] up_pat, exp_up;
        up_pat = '0;
        exp_up = '0;
        for (int i = 0; i < 20; i++) up_pat[i] = 1'b1;
        exp_up[6] = 1'b1;
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
        exp_up[16] = 1'b1;
        exp_up[19] = 1'b1;
`endif
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cyc(up_pat[k], 1'b0, 1'b0);
            n_tests++;
            if (boton_aumenta !== exp_up[k]) begin
                n_fail++;
                $display("FAIL clean_press aumenta cycle %0d: got %b expected %b",
                         k, boton_aumenta, exp_up[k]);
            end
            n_tests++;
            if (boton_disminuye !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_press disminuye cycle %0d: got %b expected 0",
                         k, boton_disminuye);
            end
        end
    endtask

    task automatic test_down_press();
        logic [63:0] exp_dn;
        exp_dn = '0;
        exp_dn[6] = 1'b1;
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
        exp_dn[16] = 1'b1;
        exp_dn[19] = 1'b1;
`endif
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            n_tests++;
            if (boton_disminuye !== exp_dn[k] || boton_aumenta !== 1'b0) begin
                n_fail++;
                $display("FAIL down_press cycle %0d: disminuye=%b aumenta=%b expected %b 0",
                         k, boton_disminuye, boton_aumenta, exp_dn[k]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [63:0] up_pat, exp_up;
        up_pat = '0;
        exp_up = '0;
        up_pat[0] = 1'b1;
        up_pat[2] = 1'b1;
        for (int i = 4; i < 20; i++) up_pat[i] = 1'b1;
        exp_up[10] = 1'b1;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cyc(up_pat[k], 1'b0, 1'b0);
            n_tests++;
            if (boton_aumenta !== exp_up[k]) begin
                n_fail++;
                $display("FAIL bounce aumenta cycle %0d: got %b expected %b",
                         k, boton_aumenta, exp_up[k]);
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic [63:0] up_pat, exp_up;
        up_pat = '0;
        exp_up = '0;
        for (int i = 0; i < 30; i++) up_pat[i] = 1'b1;
        exp_up[6] = 1'b1;
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
        exp_up[16] = 1'b1;
        exp_up[19] = 1'b1;
        exp_up[22] = 1'b1;
        exp_up[25] = 1'b1;
        exp_up[28] = 1'b1;
        exp_up[31] = 1'b1;
        exp_up[34] = 1'b1;
`endif
        do_reset();
        for (int k = 0; k < 46; k++) begin
            cyc(up_pat[k], 1'b0, 1'b0);
            n_tests++;
            if (boton_aumenta !== exp_up[k] || boton_disminuye !== 1'b0) begin
                n_fail++;
                $display("FAIL auto_repeat cycle %0d: aumenta=%b disminuye=%b expected %b 0",
                         k, boton_aumenta, boton_disminuye, exp_up[k]);
            end
        end
    endtask

    task automatic test_both_pressed();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            n_tests++;
            if (boton_aumenta !== 1'b0 || boton_disminuye !== 1'b0) begin
                n_fail++;
                $display("FAIL both_pressed cycle %0d: aumenta=%b disminuye=%b expected 0 0",
                         k, boton_aumenta, boton_disminuye);
            end
        end
    endtask

    task automatic test_second_while_held();
        logic [63:0] exp_up;
        exp_up = '0;
        exp_up[6] = 1'b1;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            cyc(1'b1, (k >= 8) ? 1'b1 : 1'b0, 1'b0);
            n_tests++;
            if (boton_aumenta !== exp_up[k] || boton_disminuye !== 1'b0) begin
                n_fail++;
                $display("FAIL second_while_held cycle %0d: aumenta=%b disminuye=%b expected %b 0",
                         k, boton_aumenta, boton_disminuye, exp_up[k]);
            end
        end
    endtask

    task automatic test_reset_while_held();
        logic [63:0] rst_pat, exp_up;
        rst_pat = '0;
        exp_up  = '0;
        rst_pat[10] = 1'b1;
        rst_pat[11] = 1'b1;
        exp_up[6]  = 1'b1;
        exp_up[18] = 1'b1;
        do_reset();
        for (int k = 0; k < 25; k++) begin
            cyc(1'b1, 1'b0, rst_pat[k]);
            n_tests++;
            if (boton_aumenta !== exp_up[k] || boton_disminuye !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_while_held cycle %0d: aumenta=%b disminuye=%b expected %b 0",
                         k, boton_aumenta, boton_disminuye, exp_up[k]);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [63:0] up_pat, exp_up;
        up_pat = '0;
        exp_up = '0;
        for (int i = 0; i < 20; i++) up_pat[i] = 1'b1;
        up_pat[10] = 1'b0;
        up_pat[11] = 1'b0;
        exp_up[6] = 1'b1;
`ifdef ACONDICIONADOR_AUTO_REPEAT_EN
        exp_up[16] = 1'b1;
        exp_up[19] = 1'b1;
`endif
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cyc(up_pat[k], 1'b0, 1'b0);
            n_tests++;
            if (boton_aumenta !== exp_up[k]) begin
                n_fail++;
                $display("FAIL release_bounce aumenta cycle %0d: got %b expected %b",
                         k, boton_aumenta, exp_up[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_down_press();
        test_bounce();
        test_auto_repeat();
        test_both_pressed();
        test_second_while_held();
        test_reset_while_held();
        test_release_bounce();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
